// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - control-unit to data-memory request/response bundle
interface mem_responder_if;
    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC;
    logic        MSET;

    modport master (
        output RAM_enable, RAM_OpCode, Address, DataIn,
        input  DataOut, MFC, MSET
    );

    modport slave (
        input  RAM_enable, RAM_OpCode, Address, DataIn,
        output DataOut, MFC, MSET
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - big-endian byte memory answering MAR/MDR requests with MFC/MSET
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            RESET,
    mem_responder_if.slave  bus
);
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE, S_ERR} state_t;

    state_t                 state;
    logic [5:0]             op_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [31:0]            data_q;
    logic [3:0]             count;
    logic [31:0]            data_out;
    logic                   mfc;
    logic                   mset;

    logic [7:0]             mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0]  a1, a2, a3;
    logic [7:0]             b0, b1, b2, b3;
    logic [31:0]            load_val;
    logic                   is_load;
    logic                   mem_we;
    logic                   unused_addr_bits;

    assign bus.DataOut = data_out;
    assign bus.MFC     = mfc;
    assign bus.MSET    = mset;

    // Upper address bits never reach the array; accesses wrap modulo the array size.
    assign unused_addr_bits = ^bus.Address[31:ADDR_WIDTH];

    function automatic logic req_ok(input logic [5:0] op, input logic [1:0] a);
        case (op)
            OP_LD, OP_ST:             return a == 2'b00;
            OP_LDUH, OP_LDSH, OP_STH: return !a[0];
            OP_LDUB, OP_LDSB, OP_STB: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    assign a1 = addr_q + ADDR_WIDTH'(1);
    assign a2 = addr_q + ADDR_WIDTH'(2);
    assign a3 = addr_q + ADDR_WIDTH'(3);

    always_comb begin
        b0 = mem[addr_q];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
    end

    always_comb begin
        load_val = '0;
        is_load  = 1'b1;
        case (op_q)
            OP_LD:   load_val = {b0, b1, b2, b3};
            OP_LDUB: load_val = {24'd0, b0};
            OP_LDSB: load_val = {{24{b0[7]}}, b0};
            OP_LDUH: load_val = {16'd0, b0, b1};
            OP_LDSH: load_val = {{16{b0[7]}}, b0, b1};
            default: is_load  = 1'b0;
        endcase
    end

    // Gating with RESET keeps a reset that coincides with ACCESS from committing a store.
    assign mem_we = (state == S_ACCESS) && !RESET;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            case (op_q)
                OP_ST: begin
                    mem[addr_q] <= data_q[31:24];
                    mem[a1]     <= data_q[23:16];
                    mem[a2]     <= data_q[15:8];
                    mem[a3]     <= data_q[7:0];
                end
                OP_STH: begin
                    mem[addr_q] <= data_q[15:8];
                    mem[a1]     <= data_q[7:0];
                end
                OP_STB:  mem[addr_q] <= data_q[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            count    <= '0;
            data_out <= '0;
            mfc      <= 1'b0;
            mset     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.RAM_enable) begin
                        op_q   <= bus.RAM_OpCode;
                        addr_q <= bus.Address[ADDR_WIDTH-1:0];
                        data_q <= bus.DataIn;
                        if (!req_ok(bus.RAM_OpCode, bus.Address[1:0])) begin
                            state <= S_ERR;
                        end else if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                            count <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    // Dropping the request wins over a counter that just expired.
                    if (!bus.RAM_enable) begin
                        state <= S_IDLE;
                    end else if (count == 4'd0) begin
                        state <= S_ACCESS;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_ACCESS: begin
                    mfc   <= 1'b1;
                    state <= S_DONE;
                    if (is_load) begin
                        data_out <= load_val;
                    end
                end
                S_DONE: begin
                    if (!bus.RAM_enable) begin
                        mfc   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (!bus.RAM_enable) begin
                        mset  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        mset  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed vector bench for mem_responder
module tb_mem_responder;
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_SWAP = 6'b001111;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] din;
        bit          err;
        logic [31:0] dout;
    } vec_t;

    logic        Clk = 1'b0;
    logic        RESET;
    logic        en, en_w0, en_w5;
    logic [5:0]  op;
    logic [31:0] addr, din;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[$];

    mem_responder_if bm ();
    mem_responder_if b0 ();
    mem_responder_if b5 ();

    assign bm.RAM_enable = en;    assign bm.RAM_OpCode = op; assign bm.Address = addr; assign bm.DataIn = din;
    assign b0.RAM_enable = en_w0; assign b0.RAM_OpCode = op; assign b0.Address = addr; assign b0.DataIn = din;
    assign b5.RAM_enable = en_w5; assign b5.RAM_OpCode = op; assign b5.Address = addr; assign b5.DataIn = din;

    mem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) u_dut (.Clk(Clk), .RESET(RESET), .bus(bm));
    mem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) u_w0  (.Clk(Clk), .RESET(RESET), .bus(b0));
    mem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(5)) u_w5  (.Clk(Clk), .RESET(RESET), .bus(b5));

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One full handshake on the main DUT: accept, wait for MFC/MSET, release, confirm clear.
    task automatic run_req(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [1:0] resp,
                           output logic [31:0] dout, output logic cleared);
        op = o; addr = a; din = d; en = 1'b1;
        tick();
        lat = -1; resp = 2'b00; dout = bm.DataOut;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bm.MFC || bm.MSET) begin
                lat = k; resp = {bm.MFC, bm.MSET}; dout = bm.DataOut;
                break;
            end
        end
        en = 1'b0;
        tick();
        cleared = !bm.MFC && !bm.MSET;
    endtask

    task automatic sweep_req(input bit sel5, input logic [5:0] o, input logic [31:0] a,
                             input logic [31:0] d, input int exp_lat, input logic [31:0] exp_dout);
        int lat;
        logic [31:0] dv;
        op = o; addr = a; din = d;
        if (sel5) en_w5 = 1'b1; else en_w0 = 1'b1;
        tick();
        lat = -1; dv = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (sel5 ? b5.MFC : b0.MFC) begin
                lat = k; dv = sel5 ? b5.DataOut : b0.DataOut;
                break;
            end
        end
        check(sel5 ? "w5_latency" : "w0_latency", lat, exp_lat);
        check(sel5 ? "w5_dout" : "w0_dout", dv, exp_dout);
        en_w0 = 1'b0; en_w5 = 1'b0;
        tick();
        check("sweep_mfc_clear", {31'd0, sel5 ? b5.MFC : b0.MFC}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [1:0]  resp;
        logic [31:0] dout;
        logic        cleared;
        int          held;

        vecs.push_back('{OP_ST,   32'h010, 32'hDEADBEEF, 1'b0, 32'h00000000});
        vecs.push_back('{OP_ST,   32'h020, 32'h11223344, 1'b0, 32'h00000000});
        vecs.push_back('{OP_ST,   32'h030, 32'h01020304, 1'b0, 32'h00000000});
        vecs.push_back('{OP_LD,   32'h010, 32'h0,        1'b0, 32'hDEADBEEF});
        vecs.push_back('{OP_LDUB, 32'h010, 32'h0,        1'b0, 32'h000000DE});
        vecs.push_back('{OP_LDSB, 32'h013, 32'h0,        1'b0, 32'hFFFFFFEF});
        vecs.push_back('{OP_STH,  32'h022, 32'h12348001, 1'b0, 32'hFFFFFFEF});
        vecs.push_back('{OP_LDSH, 32'h022, 32'h0,        1'b0, 32'hFFFF8001});
        vecs.push_back('{OP_LDUH, 32'h022, 32'h0,        1'b0, 32'h00008001});
        vecs.push_back('{OP_LD,   32'h020, 32'h0,        1'b0, 32'h11228001});
        vecs.push_back('{OP_LD,   32'h011, 32'h0,        1'b1, 32'h11228001});
        vecs.push_back('{OP_SWAP, 32'h010, 32'h0,        1'b1, 32'h11228001});
        vecs.push_back('{OP_LDUH, 32'h021, 32'h0,        1'b1, 32'h11228001});
        vecs.push_back('{OP_STH,  32'h011, 32'h0,        1'b1, 32'h11228001});
        vecs.push_back('{OP_LD,   32'h010, 32'h0,        1'b0, 32'hDEADBEEF});
        vecs.push_back('{OP_STB,  32'h200, 32'h0000005A, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{OP_LDUB, 32'h000, 32'h0,        1'b0, 32'h0000005A});
        vecs.push_back('{OP_STB,  32'h1FF, 32'h12345680, 1'b0, 32'h0000005A});
        vecs.push_back('{OP_LDSB, 32'h3FF, 32'h0,        1'b0, 32'hFFFFFF80});
        vecs.push_back('{OP_LDUB, 32'h1FF, 32'h0,        1'b0, 32'h00000080});
        vecs.push_back('{OP_LDD,  32'h010, 32'h0,        1'b1, 32'h00000080});
        vecs.push_back('{OP_STB,  32'h011, 32'hFFFFFF77, 1'b0, 32'h00000080});
        vecs.push_back('{OP_LD,   32'h010, 32'h0,        1'b0, 32'hDE77BEEF});

        RESET = 1'b1; en = 1'b0; en_w0 = 1'b0; en_w5 = 1'b0;
        op = '0; addr = '0; din = '0;
        repeat (2) tick();
        check("reset_dout", bm.DataOut, 32'h0);
        check("reset_mfc",  {31'd0, bm.MFC},  32'd0);
        check("reset_mset", {31'd0, bm.MSET}, 32'd0);
        RESET = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_req(vecs[i].op, vecs[i].addr, vecs[i].din, lat, resp, dout, cleared);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].err ? 32'd1 : 32'd3);
            check($sformatf("vec%0d_resp", i), {30'd0, resp}, vecs[i].err ? 32'd1 : 32'd2);
            check($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
            check($sformatf("vec%0d_clear", i), {31'd0, cleared}, 32'd1);
        end

        // Request held high past MFC; inputs changed after accept must not matter.
        op = OP_LD; addr = 32'h10; din = '0; en = 1'b1;
        tick();
        op = OP_ST; addr = 32'h14; din = 32'h0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bm.MFC) begin lat = k; break; end
        end
        check("hold_latency", lat, 32'd3);
        check("hold_dout", bm.DataOut, 32'hDE77BEEF);
        held = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bm.MFC && !bm.MSET) held++;
        end
        check("hold_mfc_stays", held, 32'd4);
        en = 1'b0;
        tick();
        check("hold_clear", {31'd0, bm.MFC}, 32'd0);
        run_req(OP_LD, 32'h10, 32'h0, lat, resp, dout, cleared);
        check("hold_no_second_access", dout, 32'hDE77BEEF);

        // Abort in WAIT on the same edge the counter expires.
        op = OP_ST; addr = 32'h30; din = 32'hAAAAAAAA; en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        held = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bm.MFC || bm.MSET) held++;
        end
        check("abort_no_mfc", held, 32'd0);
        run_req(OP_LD, 32'h30, 32'h0, lat, resp, dout, cleared);
        check("abort_mem_kept", dout, 32'h01020304);

        // RESET pulsed while the store is waiting.
        op = OP_ST; addr = 32'h30; din = 32'hAAAAAAAA; en = 1'b1;
        tick();
        RESET = 1'b1;
        #2;
        check("rst_dout", bm.DataOut, 32'h0);
        check("rst_mfc",  {31'd0, bm.MFC}, 32'd0);
        tick();
        RESET = 1'b0; en = 1'b0;
        repeat (4) tick();
        check("rst_no_mfc", {30'd0, bm.MFC, bm.MSET}, 32'd0);
        run_req(OP_LD, 32'h30, 32'h0, lat, resp, dout, cleared);
        check("rst_mem_kept", dout, 32'h01020304);

        sweep_req(1'b0, OP_ST, 32'h8, 32'h0BADF00D, 1, 32'h0);
        sweep_req(1'b0, OP_LD, 32'h8, 32'h0, 1, 32'h0BADF00D);
        sweep_req(1'b1, OP_ST, 32'h8, 32'h0BADF00D, 6, 32'h0);
        sweep_req(1'b1, OP_LDSH, 32'h8, 32'h0, 6, 32'h00000BAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Synchronous byte-addressed data memory that answers the control unit's MAR/MDR memory requests. It sits on the far side of the `RAM_enable` / `RAM_OpCode` / `MFC` / `MSET` interface. It executes SPARC V8 integer load/store size variants in big-endian order and signals completion with `MFC` or failure with `MSET`. Each access uses a four-phase handshake with a configurable number of wait states.

## Interface
- `ADDR_WIDTH`, default 9: byte-array index width; the array holds 2^ADDR_WIDTH bytes.
- `WAIT_CYCLES`, default 2: number of wait-state cycles before an access is performed (0–15).
- `Clk` input 1: rising-edge clock.
- `RESET` input 1: reset, asynchronous, active-high.
- `RAM_enable` input 1: request strobe, level-sensitive; held high until `MFC` or `MSET` is seen.
- `RAM_OpCode` input 6: op3 field of the instruction.
- `Address` input 32: byte address, taken from MAR.
- `DataIn` input 32: store data, taken from MDR.
- `DataOut` output 32: load result, delivered to the MDR mux.
- `MFC` output 1: memory function complete.
- `MSET` output 1: memory error (misaligned address or unsupported op3).

## Operation
- States: IDLE, WAIT, ACCESS, DONE, ERR.
- **IDLE**
  - On a rising edge with `RAM_enable=1`, latch `RAM_OpCode`, `Address` and `DataIn`, then check the request.
  - Unsupported opcode or misaligned address → ERR.
  - Otherwise → WAIT if `WAIT_CYCLES>0`, else → ACCESS.
- **WAIT**
  - A 4-bit counter loads `WAIT_CYCLES-1` and decrements each edge.
  - At count 0 → ACCESS.
  - `RAM_enable=0` at any edge → IDLE (abort: no access, no `MFC`).
- **ACCESS**: perform the access on this edge, set `MFC=1`, → DONE.
- **DONE**: hold `MFC=1` and `DataOut`; on an edge with `RAM_enable=0` → IDLE and clear `MFC`.
- **ERR**: hold `MSET=1`; on an edge with `RAM_enable=0` → IDLE and clear `MSET`. Memory is not modified.
- Opcodes, with A = latched address:
  - 000000 LD: word, requires A[1:0]=0.
  - 000001 LDUB: zero-extended byte.
  - 000010 LDUH: zero-extended half, requires A[0]=0.
  - 001001 LDSB: sign-extended byte.
  - 001010 LDSH: sign-extended half, requires A[0]=0.
  - 000100 ST: word, requires A[1:0]=0.
  - 000101 STB: writes `DataIn[7:0]`.
  - 000110 STH: writes `DataIn[15:0]`, requires A[0]=0.
  - Every other op3 (LDD, STD, SWAP, …) goes to ERR.
- Byte ordering is big-endian: mem[A] = bits 31:24 of a word, mem[A+1] = bits 23:16, and so on.
- Only A[ADDR_WIDTH-1:0] indexes the array; upper bits are ignored, so addresses wrap modulo 2^ADDR_WIDTH.
- Stores leave `DataOut` unchanged. Loads update `DataOut` only in ACCESS.

## Timing
- Reset values: `DataOut=0`, `MFC=0`, `MSET=0`, state IDLE, counter 0. Array contents are not cleared.
- Latency: the request is accepted at edge E0, and `MFC` rises after edge E0+WAIT_CYCLES+1.
  - Default `WAIT_CYCLES=2`: `MFC` high after edge 3.
  - `WAIT_CYCLES=0`: `MFC` high after edge 1.
- `MSET` rises after edge E0+1, independent of `WAIT_CYCLES`.
- Inputs are sampled only at the accept edge; later changes to `Address`, `DataIn` or `RAM_OpCode` have no effect on the current access.
- `MFC`/`MSET` fall after the first edge that sees `RAM_enable=0`.
- A new request needs at least one edge with `RAM_enable=0` after completion, so back-to-back accesses cost WAIT_CYCLES+3 cycles.
- `RESET` mid-operation: return to IDLE immediately and abandon any pending store. The array is written only in ACCESS.
- `RESET` in the same cycle as ACCESS: reset wins and no write occurs.
- `RAM_enable` falling in the same edge the counter reaches 0: abort takes priority and no access occurs.

## Test plan
- Word store/load:
  - ST with `Address`=0x10, `DataIn`=0xDEADBEEF, `WAIT_CYCLES`=2 → `MFC` high after edge 3, `DataOut` unchanged.
  - LD 0x10 → `DataOut`=0xDEADBEEF with `MFC`.
  - LDUB 0x10 → 0x000000DE.
  - LDSB 0x13 → 0xFFFFFFEF.
- Halfword:
  - STH 0x22 with `DataIn`=0x12348001.
  - LDSH 0x22 → 0xFFFF8001; LDUH 0x22 → 0x00008001.
  - LD 0x20 → bytes 0x20–0x21 unchanged, low half 0x8001.
- Errors:
  - LD at 0x11 → `MSET` after edge 1, `MFC` stays 0, memory unchanged.
  - Opcode 001111 (SWAP) → `MSET`.
  - In both cases, deasserting `RAM_enable` clears `MSET` at the next edge.
- Abort:
  - ST 0x30 with 0xAAAAAAAA, drop `RAM_enable` after edge 1 → no `MFC`.
  - LD 0x30 afterwards returns the prior contents.
  - Repeat the store with `RESET` pulsed in WAIT → same result, outputs at reset values.
- Wrap and handshake:
  - With `ADDR_WIDTH`=9, STB to 0x200 with 0x5A → LDUB 0x000 returns 0x5A.
  - Holding `RAM_enable` high after `MFC` keeps `MFC` high with no second access.
- Latency sweep: `WAIT_CYCLES`=0 and 5 → `MFC` after edge 1 and edge 6 respectively.
